wbu_stage: RTL and testbench

Write-back stage directly downstream of the load/store stage. It latches the LSU result bundle, selects the register-file write data (ALU, memory or CSR) and commits it. It owns the machine-mode CSRs mstatus, mtvec, mepc and mcause. It takes ecall, mret and machine-timer interrupts, and drives the pipeline flush and redirect PC back to the front end.

---
 rtl/wb_pkg.sv | 38 +++
 rtl/wb_csr_file.sv | 117 +++++++++++
 rtl/wbu_stage.sv | 135 +++++++++++++
 tb/tb_wbu_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants for the write-back stage: CSR addresses, RegSrc encoding,
// trap causes, SYSTEM instruction encodings and mstatus bit positions.
package wb_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;

    typedef enum logic [1:0] {
        REGSRC_ALU     = 2'd0,
        REGSRC_MEM     = 2'd1,
        REGSRC_CSR     = 2'd2,
        REGSRC_ALU_ALT = 2'd3
    } regsrc_e;

    localparam logic [63:0] MCAUSE_ECALL_M = 64'd11;
    localparam logic [63:0] MCAUSE_MTI     = 64'h8000_0000_0000_0007;

    localparam logic [31:0] INST_ECALL = 32'h0000_0073;
    localparam logic [31:0] INST_MRET  = 32'h3020_0073;
    localparam logic [6:0]  OPC_SYSTEM = 7'h73;

    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_CSRRS = 3'b010;
    localparam logic [2:0] F3_CSRRC = 3'b011;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    function automatic logic is_csr_op(input logic [6:0] opc, input logic [2:0] f3);
        return (opc == OPC_SYSTEM) &&
               (f3 == F3_CSRRW || f3 == F3_CSRRS || f3 == F3_CSRRC);
    endfunction

endpackage

// File: rtl/wb_csr_file.sv
// Machine-mode CSR file: mstatus/mtvec/mepc/mcause, read mux, CSRRW/S/C and trap/mret updates.
// Optional WB_COUNTERS_EN adds mcycle and minstret.
module wb_csr_file
    import wb_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_en,
    input  logic [2:0]      csr_funct3,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_src,
    input  logic            src_is_x0,
    input  logic            trap_enter,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic            mret,
`ifdef WB_COUNTERS_EN
    input  logic            retire,
`endif
    output logic [XLEN-1:0] csr_rdata,
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mepc,
    output logic            mie
);

    logic [XLEN-1:0] mstatus;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] csr_wval;
    logic            csr_wen;
`ifdef WB_COUNTERS_EN
    logic [63:0]     mcycle;
    logic [63:0]     minstret;
`endif

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS:  csr_rdata = mstatus;
            CSR_MTVEC:    csr_rdata = mtvec;
            CSR_MEPC:     csr_rdata = mepc;
            CSR_MCAUSE:   csr_rdata = mcause;
`ifdef WB_COUNTERS_EN
            CSR_MCYCLE:   csr_rdata = XLEN'(mcycle);
            CSR_MINSTRET: csr_rdata = XLEN'(minstret);
`else
            CSR_MCYCLE, CSR_MINSTRET: csr_rdata = '0;
`endif
            default:      csr_rdata = '0;
        endcase
    end

    // Set/clear forms with rs1=x0 are pure reads and must not write.
    always_comb begin
        csr_wval = csr_src;
        csr_wen  = 1'b0;
        case (csr_funct3)
            F3_CSRRW: begin
                csr_wval = csr_src;
                csr_wen  = csr_en;
            end
            F3_CSRRS: begin
                csr_wval = csr_rdata | csr_src;
                csr_wen  = csr_en && !src_is_x0;
            end
            F3_CSRRC: begin
                csr_wval = csr_rdata & ~csr_src;
                csr_wen  = csr_en && !src_is_x0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mstatus <= '0;
            mtvec   <= MTVEC_RST;
            mepc    <= '0;
            mcause  <= '0;
        end else if (trap_enter) begin
            mepc                  <= trap_pc;
            mcause                <= trap_cause;
            mstatus[MSTATUS_MPIE] <= mstatus[MSTATUS_MIE];
            mstatus[MSTATUS_MIE]  <= 1'b0;
        end else if (mret) begin
            mstatus[MSTATUS_MIE]  <= mstatus[MSTATUS_MPIE];
            mstatus[MSTATUS_MPIE] <= 1'b1;
        end else if (csr_wen) begin
            case (csr_addr)
                CSR_MSTATUS: mstatus <= csr_wval;
                CSR_MTVEC:   mtvec   <= csr_wval;
                CSR_MEPC:    mepc    <= csr_wval;
                CSR_MCAUSE:  mcause  <= csr_wval;
                default: ;
            endcase
        end
    end

`ifdef WB_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (csr_wen && csr_addr == CSR_MCYCLE) mcycle <= 64'(csr_wval);
            else                                   mcycle <= mcycle + 64'd1;
            if (csr_wen && csr_addr == CSR_MINSTRET) minstret <= 64'(csr_wval);
            else if (retire)                         minstret <= minstret + 64'd1;
        end
    end
`endif

    assign mie = mstatus[MSTATUS_MIE];

endmodule

// File: rtl/wbu_stage.sv
// Write-back stage: latches the LSU bundle, selects RF write data, commits, and raises
// flush/redirect for ecall, mret and timer interrupts. Optional feature macro: WB_COUNTERS_EN.
module wbu_stage
    import wb_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter int              INST_W    = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_to_wb_valid,
    output logic              wb_allowin,
    input  logic [XLEN-1:0]   i_memout,
    input  logic [XLEN-1:0]   i_ALUres,
    input  logic [1:0]        i_RegSrc,
    input  logic              i_RegWr,
    input  logic [XLEN-1:0]   i_R_rs1,
    input  logic [INST_W-1:0] i_inst,
    input  logic [XLEN-1:0]   i_pc,
    input  logic              clint_mtip,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              mstatus_MIE,
    output logic              pipeline_flush,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              wb_commit
);

    logic              vld_p1;
    logic [XLEN-1:0]   memout_p1;
    logic [XLEN-1:0]   alures_p1;
    regsrc_e           regsrc_p1;
    logic              regwr_p1;
    logic [XLEN-1:0]   rs1_p1;
    logic [INST_W-1:0] inst_p1;
    logic [XLEN-1:0]   pc_p1;
    logic              mtip_p1;

    logic              vld;
    logic [4:0]        rd;
    logic              intr_take;
    logic              ecall_take;
    logic              mret_take;
    logic              take_trap;
    logic              csr_en;
    logic [XLEN-1:0]   trap_cause;
    logic [XLEN-1:0]   csr_rdata;
    logic [XLEN-1:0]   mtvec;
    logic [XLEN-1:0]   mepc;
    logic [XLEN-1:0]   wdata_sel;

    assign wb_allowin = rst;

    // LSU -> WB boundary: a bundle arriving alongside a flush is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1    <= 1'b0;
            memout_p1 <= '0;
            alures_p1 <= '0;
            regsrc_p1 <= REGSRC_ALU;
            regwr_p1  <= 1'b0;
            rs1_p1    <= '0;
            inst_p1   <= '0;
            pc_p1     <= '0;
            mtip_p1   <= 1'b0;
        end else begin
            vld_p1 <= lsu_to_wb_valid && wb_allowin && !pipeline_flush;
            if (lsu_to_wb_valid && wb_allowin) begin
                memout_p1 <= i_memout;
                alures_p1 <= i_ALUres;
                regsrc_p1 <= regsrc_e'(i_RegSrc);
                regwr_p1  <= i_RegWr;
                rs1_p1    <= i_R_rs1;
                inst_p1   <= i_inst;
                pc_p1     <= i_pc;
                mtip_p1   <= clint_mtip;
            end
        end
    end

    // Commit cycle: gating with rst discards a commit that coincides with reset.
    assign vld        = vld_p1 && rst;
    assign rd         = inst_p1[11:7];
    assign intr_take  = vld && mtip_p1;
    assign ecall_take = vld && !mtip_p1 && (inst_p1 == INST_W'(INST_ECALL));
    assign mret_take  = vld && !mtip_p1 && (inst_p1 == INST_W'(INST_MRET));
    assign take_trap  = intr_take || ecall_take || mret_take;
    assign csr_en     = vld && !intr_take && is_csr_op(inst_p1[6:0], inst_p1[14:12]);
    assign trap_cause = intr_take ? XLEN'(MCAUSE_MTI) : XLEN'(MCAUSE_ECALL_M);

    wb_csr_file #(
        .XLEN      (XLEN),
        .MTVEC_RST (MTVEC_RST)
    ) u_csr (
        .clk        (clk),
        .rst        (rst),
        .csr_en     (csr_en),
        .csr_funct3 (inst_p1[14:12]),
        .csr_addr   (inst_p1[31:20]),
        .csr_src    (rs1_p1),
        .src_is_x0  (inst_p1[19:15] == 5'd0),
        .trap_enter (intr_take || ecall_take),
        .trap_pc    (pc_p1),
        .trap_cause (trap_cause),
        .mret       (mret_take),
`ifdef WB_COUNTERS_EN
        .retire     (wb_commit),
`endif
        .csr_rdata  (csr_rdata),
        .mtvec      (mtvec),
        .mepc       (mepc),
        .mie        (mstatus_MIE)
    );

    always_comb begin
        wdata_sel = alures_p1;
        case (regsrc_p1)
            REGSRC_MEM:     wdata_sel = memout_p1;
            REGSRC_CSR:     wdata_sel = csr_rdata;
            REGSRC_ALU_ALT: wdata_sel = alures_p1;
            default:        wdata_sel = alures_p1;
        endcase
    end

    assign rf_we          = vld && regwr_p1 && (rd != 5'd0) && !take_trap;
    assign rf_waddr       = vld ? rd : 5'd0;
    assign rf_wdata       = vld ? wdata_sel : '0;
    assign wb_commit      = vld && !intr_take;
    assign pipeline_flush = take_trap;
    // Redirect uses the pre-update mtvec/mepc.
    assign redirect_pc    = mret_take ? mepc : ((intr_take || ecall_take) ? mtvec : '0);

endmodule

// File: tb/tb_wbu_stage.sv
// Bench for wbu_stage: directed steps plus randomized instructions checked against
// a CSR/trap reference model built from the architectural rules.
module tb_wbu_stage;

    localparam logic [63:0] MTVEC_RST_TB = 64'h0000_0000_0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lsu_to_wb_valid = 1'b0;
    logic        wb_allowin;
    logic [63:0] i_memout = '0;
    logic [63:0] i_ALUres = '0;
    logic [1:0]  i_RegSrc = '0;
    logic        i_RegWr = 1'b0;
    logic [63:0] i_R_rs1 = '0;
    logic [31:0] i_inst = '0;
    logic [63:0] i_pc = '0;
    logic        clint_mtip = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        mstatus_MIE;
    logic        pipeline_flush;
    logic [63:0] redirect_pc;
    logic        wb_commit;

    wbu_stage #(.XLEN(64), .INST_W(32), .MTVEC_RST(MTVEC_RST_TB)) dut (
        .clk(clk), .rst(rst), .lsu_to_wb_valid(lsu_to_wb_valid), .wb_allowin(wb_allowin),
        .i_memout(i_memout), .i_ALUres(i_ALUres), .i_RegSrc(i_RegSrc), .i_RegWr(i_RegWr),
        .i_R_rs1(i_R_rs1), .i_inst(i_inst), .i_pc(i_pc), .clint_mtip(clint_mtip),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .mstatus_MIE(mstatus_MIE),
        .pipeline_flush(pipeline_flush), .redirect_pc(redirect_pc), .wb_commit(wb_commit)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference architectural state
    logic [63:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
    // Expected commit-cycle outputs of the most recent modelled instruction
    logic        e_we, e_commit, e_flush;
    logic [4:0]  e_waddr;
    logic [63:0] e_wdata, e_redirect;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_mstatus = '0;
        m_mtvec   = MTVEC_RST_TB;
        m_mepc    = '0;
        m_mcause  = '0;
    endtask

    function automatic logic [63:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 64'h0;
        endcase
    endfunction

    task automatic m_write(input logic [11:0] a, input logic [63:0] v);
        case (a)
            12'h300: m_mstatus = v;
            12'h305: m_mtvec   = v;
            12'h341: m_mepc    = v;
            12'h342: m_mcause  = v;
            default: ;
        endcase
    endtask

    // Predict commit outputs from the pre-state, then apply the instruction's effect.
    task automatic m_step(input logic [31:0] inst, input logic [63:0] pc, alu, mem, rs1,
                          input logic [1:0] regsrc, input logic regwr, input logic mtip);
        logic intr, ecall, mret, is_csr, old_mie;
        logic [2:0]  f3;
        logic [63:0] old;
        intr   = mtip;
        ecall  = !intr && inst == 32'h0000_0073;
        mret   = !intr && inst == 32'h3020_0073;
        f3     = inst[14:12];
        is_csr = inst[6:0] == 7'h73 && (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3);
        old    = m_read(inst[31:20]);
        e_flush    = intr || ecall || mret;
        e_redirect = mret ? m_mepc : (e_flush ? m_mtvec : 64'h0);
        e_wdata    = (regsrc == 2'd1) ? mem : ((regsrc == 2'd2) ? old : alu);
        e_waddr    = inst[11:7];
        e_we       = regwr && inst[11:7] != 5'd0 && !e_flush;
        e_commit   = !intr;
        if (intr || ecall) begin
            old_mie      = m_mstatus[3];
            m_mepc       = pc;
            m_mcause     = intr ? 64'h8000_0000_0000_0007 : 64'd11;
            m_mstatus[7] = old_mie;
            m_mstatus[3] = 1'b0;
        end else if (mret) begin
            m_mstatus[3] = m_mstatus[7];
            m_mstatus[7] = 1'b1;
        end else if (is_csr && (f3 == 3'd1 || inst[19:15] != 5'd0)) begin
            case (f3)
                3'd1:    m_write(inst[31:20], rs1);
                3'd2:    m_write(inst[31:20], old | rs1);
                default: m_write(inst[31:20], old & ~rs1);
            endcase
        end
    endtask

    task automatic drive(input logic [31:0] inst, input logic [63:0] pc, alu, mem, rs1,
                         input logic [1:0] regsrc, input logic regwr, input logic mtip);
        i_inst = inst; i_pc = pc; i_ALUres = alu; i_memout = mem; i_R_rs1 = rs1;
        i_RegSrc = regsrc; i_RegWr = regwr; clint_mtip = mtip; lsu_to_wb_valid = 1'b1;
    endtask

    task automatic run_instr(input string tag, input logic [31:0] inst, input logic [63:0] pc,
                             alu, mem, rs1, input logic [1:0] regsrc, input logic regwr,
                             input logic mtip);
        m_step(inst, pc, alu, mem, rs1, regsrc, regwr, mtip);
        @(negedge clk);
        drive(inst, pc, alu, mem, rs1, regsrc, regwr, mtip);
        @(posedge clk); #1;
        lsu_to_wb_valid = 1'b0;
        clint_mtip = 1'b0;
        check({tag, ".rf_we"},    64'(rf_we),          64'(e_we));
        check({tag, ".waddr"},    64'(rf_waddr),       64'(e_waddr));
        check({tag, ".wdata"},    rf_wdata,            e_wdata);
        check({tag, ".commit"},   64'(wb_commit),      64'(e_commit));
        check({tag, ".flush"},    64'(pipeline_flush), 64'(e_flush));
        check({tag, ".redirect"}, redirect_pc,         e_redirect);
        @(posedge clk); #1;
        check({tag, ".flush_1cyc"},  64'(pipeline_flush), 64'h0);
        check({tag, ".commit_1cyc"}, 64'(wb_commit),      64'h0);
        check({tag, ".mie"},         64'(mstatus_MIE),    64'(m_mstatus[3]));
    endtask

    function automatic logic [31:0] csr_inst(input logic [11:0] a, input logic [4:0] rs1f,
                                             input logic [2:0] f3, input logic [4:0] rd);
        return {a, rs1f, f3, rd, 7'h73};
    endfunction

    function automatic logic [31:0] alu_inst(input logic [4:0] rd);
        return {7'h00, 5'd2, 5'd1, 3'b000, rd, 7'h33};
    endfunction

    function automatic logic [31:0] load_inst(input logic [4:0] rd);
        return {12'h000, 5'd1, 3'b011, rd, 7'h03};
    endfunction

`ifdef WB_COUNTERS_EN
    logic [11:0] addrs [7] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h7C0, 12'h7C0, 12'h123};
`else
    logic [11:0] addrs [7] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h7C0, 12'hB00, 12'hB02};
`endif

    logic [31:0] r_inst;
    logic [63:0] r_pc;
    logic [2:0]  r_f3;
    logic [4:0]  r_rs1f;
    int          sel;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.allowin", 64'(wb_allowin), 64'h0);
        check("rst.rf_we",   64'(rf_we),      64'h0);
        check("rst.commit",  64'(wb_commit),  64'h0);
        check("rst.flush",   64'(pipeline_flush), 64'h0);
        check("rst.mie",     64'(mstatus_MIE), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        m_reset();
        @(posedge clk); #1;
        check("idle.allowin",  64'(wb_allowin), 64'h1);
        check("idle.wdata",    rf_wdata,        64'h0);
        check("idle.redirect", redirect_pc,     64'h0);

        // Directed steps
        run_instr("add",  alu_inst(5'd5), 64'h8000_0000, 64'h1234, 64'h55, 64'h0, 2'd0, 1'b1, 1'b0);
        run_instr("load_x0", load_inst(5'd0), 64'h8000_0004, 64'h9, 64'hFFFF_FFFF_FFFF_FF80,
                  64'h0, 2'd1, 1'b1, 1'b0);
        run_instr("load_x9", load_inst(5'd9), 64'h8000_0008, 64'h9, 64'hFFFF_FFFF_FFFF_FF80,
                  64'h0, 2'd1, 1'b1, 1'b0);
        run_instr("csrrw_mtvec", csr_inst(12'h305, 5'd10, 3'b001, 5'd6), 64'h8000_000C,
                  64'h0, 64'h0, 64'h8000_0100, 2'd2, 1'b1, 1'b0);
        run_instr("csrrs_mtvec_rd", csr_inst(12'h305, 5'd0, 3'b010, 5'd7), 64'h8000_0010,
                  64'h0, 64'h0, 64'hFFFF, 2'd2, 1'b1, 1'b0);
        run_instr("set_mie", csr_inst(12'h300, 5'd1, 3'b010, 5'd0), 64'h8000_0014,
                  64'h0, 64'h0, 64'h8, 2'd2, 1'b1, 1'b0);
        run_instr("ecall", 32'h0000_0073, 64'h8000_0040, 64'h0, 64'h0, 64'h0, 2'd0, 1'b0, 1'b0);
        run_instr("rd_mepc", csr_inst(12'h341, 5'd0, 3'b010, 5'd8), 64'h8000_0100,
                  64'h0, 64'h0, 64'h0, 2'd2, 1'b1, 1'b0);
        run_instr("rd_mcause", csr_inst(12'h342, 5'd0, 3'b010, 5'd8), 64'h8000_0104,
                  64'h0, 64'h0, 64'h0, 2'd2, 1'b1, 1'b0);
        run_instr("rd_mstatus", csr_inst(12'h300, 5'd0, 3'b010, 5'd8), 64'h8000_0108,
                  64'h0, 64'h0, 64'h0, 2'd2, 1'b1, 1'b0);
        run_instr("mret", 32'h3020_0073, 64'h8000_010C, 64'h0, 64'h0, 64'h0, 2'd0, 1'b0, 1'b0);
        run_instr("mti", alu_inst(5'd4), 64'h8000_0010, 64'h77, 64'h0, 64'h0, 2'd0, 1'b1, 1'b1);
        run_instr("rd_mepc2", csr_inst(12'h341, 5'd0, 3'b010, 5'd8), 64'h8000_0200,
                  64'h0, 64'h0, 64'h0, 2'd2, 1'b1, 1'b0);
        run_instr("rd_mcause2", csr_inst(12'h342, 5'd0, 3'b010, 5'd8), 64'h8000_0204,
                  64'h0, 64'h0, 64'h0, 2'd2, 1'b1, 1'b0);
        run_instr("csrrc_mtvec", csr_inst(12'h305, 5'd3, 3'b011, 5'd9), 64'h8000_0208,
                  64'h0, 64'h0, 64'h100, 2'd2, 1'b1, 1'b0);
        run_instr("unk_wr", csr_inst(12'h7C0, 5'd3, 3'b001, 5'd9), 64'h8000_020C,
                  64'h0, 64'h0, 64'hABCD, 2'd2, 1'b1, 1'b0);
        run_instr("unk_rd", csr_inst(12'h7C0, 5'd0, 3'b010, 5'd9), 64'h8000_0210,
                  64'h0, 64'h0, 64'h0, 2'd2, 1'b1, 1'b0);
        run_instr("regsrc3", alu_inst(5'd12), 64'h8000_0214, 64'hBEEF, 64'h1, 64'h0, 2'd3, 1'b1, 1'b0);

        // A bundle presented while a flush is active must be dropped
        m_step(32'h0000_0073, 64'h8000_0300, 64'h0, 64'h0, 64'h0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        drive(32'h0000_0073, 64'h8000_0300, 64'h0, 64'h0, 64'h0, 2'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(alu_inst(5'd3), 64'h8000_0304, 64'h77, 64'h0, 64'h0, 2'd0, 1'b1, 1'b0);
        check("supp.flush",    64'(pipeline_flush), 64'h1);
        check("supp.redirect", redirect_pc, e_redirect);
        @(posedge clk); #1;
        lsu_to_wb_valid = 1'b0;
        check("supp.commit", 64'(wb_commit), 64'h0);
        check("supp.rf_we",  64'(rf_we),     64'h0);

        // Back-to-back bundles each commit one cycle after their handshake
        @(negedge clk);
        drive(alu_inst(5'd10), 64'h8000_0400, 64'hAAAA, 64'h0, 64'h0, 2'd0, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(alu_inst(5'd11), 64'h8000_0404, 64'hBBBB, 64'h0, 64'h0, 2'd0, 1'b1, 1'b0);
        check("b2b0.waddr", 64'(rf_waddr), 64'd10);
        check("b2b0.wdata", rf_wdata,      64'hAAAA);
        @(posedge clk); #1;
        lsu_to_wb_valid = 1'b0;
        check("b2b1.waddr",  64'(rf_waddr),  64'd11);
        check("b2b1.wdata",  rf_wdata,       64'hBBBB);
        check("b2b1.commit", 64'(wb_commit), 64'h1);
        @(posedge clk); #1;

        // Randomized instruction mix
        for (int k = 0; k < 150; k++) begin
            sel    = $urandom_range(0, 9);
            r_pc   = {$urandom(), $urandom()} & ~64'h3;
            r_f3   = 3'($urandom_range(1, 3));
            r_rs1f = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            case (sel)
                0, 1, 2: r_inst = alu_inst(5'($urandom_range(0, 31)));
                3:       r_inst = load_inst(5'($urandom_range(0, 31)));
                8:       r_inst = 32'h0000_0073;
                9:       r_inst = 32'h3020_0073;
                default: r_inst = csr_inst(addrs[$urandom_range(0, 6)], r_rs1f, r_f3,
                                           5'($urandom_range(0, 31)));
            endcase
            run_instr("rand", r_inst, r_pc, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                      {$urandom(), $urandom()}, 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        // Reset asserted during a commit carrying csrrw mepc
        @(negedge clk);
        drive(csr_inst(12'h341, 5'd1, 3'b001, 5'd9), 64'h8000_0500, 64'h0, 64'h0,
              64'hDEAD_BEEF, 2'd2, 1'b1, 1'b0);
        @(posedge clk); #1;
        lsu_to_wb_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rstmid.rf_we",   64'(rf_we),          64'h0);
        check("rstmid.commit",  64'(wb_commit),      64'h0);
        check("rstmid.wdata",   rf_wdata,            64'h0);
        check("rstmid.allowin", 64'(wb_allowin),     64'h0);
        @(posedge clk); #1;
        check("rstmid.after_waddr", 64'(rf_waddr),       64'h0);
        check("rstmid.after_flush", 64'(pipeline_flush), 64'h0);
        check("rstmid.after_mie",   64'(mstatus_MIE),    64'h0);
        rst = 1'b1;
        m_reset();
        run_instr("post_rst_mepc", csr_inst(12'h341, 5'd0, 3'b010, 5'd8), 64'h8000_0600,
                  64'h0, 64'h0, 64'h0, 2'd2, 1'b1, 1'b0);
        run_instr("post_rst_mtvec", csr_inst(12'h305, 5'd0, 3'b010, 5'd8), 64'h8000_0604,
                  64'h0, 64'h0, 64'h0, 2'd2, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
